// File: rtl/pc_source_ctrl_pkg.sv
// Shared definitions for the PC-source controller: FSM states, PC-source
// mux selector codes and exception cause codes.
package pc_source_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMMIT   = 2'd1,
    ST_EXC_SAVE = 2'd2,
    ST_EXC_WAIT = 2'd3
  } state_t;

  // PC-source mux selector codes
  localparam logic [2:0] PCS_SEQ    = 3'd0;  // PC+4 (ALU result)
  localparam logic [2:0] PCS_BRANCH = 3'd1;  // branch target (ALUOut)
  localparam logic [2:0] PCS_JUMP   = 3'd2;  // {PC[31:28],imm26,2'b00}
  localparam logic [2:0] PCS_REG    = 3'd3;  // register target
  localparam logic [2:0] PCS_VEC    = 3'd4;  // handler vector from memory
  localparam logic [2:0] PCS_EPC    = 3'd5;  // saved EPC

  // Exception cause codes
  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_OPCODE = 2'd1;
  localparam logic [1:0] CAUSE_OVF    = 2'd2;
  localparam logic [1:0] CAUSE_DIV0   = 2'd3;

endpackage

// File: rtl/pc_source_ctrl_prio.sv
// pc_req_prio: combinational priority encoder for PC-change requests.
// Order: exc_ovf > exc_opcode > exc_div0 > rte > jr > jump > branch > seq.
// Config macro DIV0_EXC_EN: when undefined, exc_div0 is masked off entirely.
module pc_req_prio
  import pc_source_ctrl_pkg::*;
#(
  parameter logic [7:0] VEC_OPCODE = 8'hFD,
  parameter logic [7:0] VEC_OVF    = 8'hFE,
  parameter logic [7:0] VEC_DIV0   = 8'hFF
) (
  input  logic       i_req_seq,
  input  logic       i_req_branch,
  input  logic       i_branch_cond,
  input  logic       i_req_jump,
  input  logic       i_req_jr,
  input  logic       i_req_rte,
  input  logic       i_exc_opcode,
  input  logic       i_exc_ovf,
  input  logic       i_exc_div0,
  output logic       o_valid,
  output logic       o_is_exc,
  output logic       o_any,
  output logic [2:0] o_code,
  output logic [7:0] o_vector,
  output logic [1:0] o_cause
);

  logic w_div0;

`ifdef DIV0_EXC_EN
  assign w_div0 = i_exc_div0;
`else
  assign w_div0 = 1'b0 & i_exc_div0;
`endif

  // Any raised request line, used for overrun detection while busy
  assign o_any = i_req_seq | i_req_branch | i_req_jump | i_req_jr | i_req_rte |
                 i_exc_opcode | i_exc_ovf | w_div0;

  // Pick the single highest-priority request; a not-taken branch commits nothing
  always_comb begin
    o_valid  = 1'b0;
    o_is_exc = 1'b0;
    o_code   = PCS_SEQ;
    o_vector = 8'h00;
    o_cause  = CAUSE_NONE;
    if (i_exc_ovf) begin
      o_valid = 1'b1; o_is_exc = 1'b1; o_code = PCS_VEC;
      o_vector = VEC_OVF; o_cause = CAUSE_OVF;
    end else if (i_exc_opcode) begin
      o_valid = 1'b1; o_is_exc = 1'b1; o_code = PCS_VEC;
      o_vector = VEC_OPCODE; o_cause = CAUSE_OPCODE;
    end else if (w_div0) begin
      o_valid = 1'b1; o_is_exc = 1'b1; o_code = PCS_VEC;
      o_vector = VEC_DIV0; o_cause = CAUSE_DIV0;
    end else if (i_req_rte) begin
      o_valid = 1'b1; o_code = PCS_EPC;
    end else if (i_req_jr) begin
      o_valid = 1'b1; o_code = PCS_REG;
    end else if (i_req_jump) begin
      o_valid = 1'b1; o_code = PCS_JUMP;
    end else if (i_req_branch) begin
      o_valid = i_branch_cond; o_code = PCS_BRANCH;
    end else if (i_req_seq) begin
      o_valid = 1'b1; o_code = PCS_SEQ;
    end
  end

endmodule

// File: rtl/pc_source_ctrl.sv
// pc_source_ctrl: sequences every PC update of the multicycle CPU and runs the
// multi-cycle exception entry (save EPC, fetch vector byte, load PC).
// Config macro DIV0_EXC_EN enables the divide-by-zero exception source.
module pc_source_ctrl
  import pc_source_ctrl_pkg::*;
#(
  parameter int         MEM_LAT    = 2,
  parameter logic [7:0] VEC_OPCODE = 8'hFD,
  parameter logic [7:0] VEC_OVF    = 8'hFE,
  parameter logic [7:0] VEC_DIV0   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_seq,
  input  logic       req_branch,
  input  logic       branch_cond,
  input  logic       req_jump,
  input  logic       req_jr,
  input  logic       req_rte,
  input  logic       exc_opcode,
  input  logic       exc_ovf,
  input  logic       exc_div0,
  output logic [2:0] pc_source,
  output logic       pc_write,
  output logic       epc_write,
  output logic       exc_mem_rd,
  output logic [7:0] exc_mem_addr,
  output logic [1:0] cause,
  output logic       busy,
  output logic       overrun
);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_pc_source, w_pc_source_nxt;
  logic       r_pc_write, w_pc_write_nxt;
  logic       r_epc_write, w_epc_write_nxt;
  logic       r_mem_rd, w_mem_rd_nxt;
  logic [7:0] r_mem_addr, w_mem_addr_nxt;
  logic [1:0] r_cause, w_cause_nxt;
  logic       r_busy;
  logic       r_overrun, w_overrun_nxt;

  logic       w_valid, w_is_exc, w_any;
  logic [2:0] w_code;
  logic [7:0] w_vector;
  logic [1:0] w_cause;

  pc_req_prio #(
    .VEC_OPCODE (VEC_OPCODE),
    .VEC_OVF    (VEC_OVF),
    .VEC_DIV0   (VEC_DIV0)
  ) u_prio (
    .i_req_seq     (req_seq),
    .i_req_branch  (req_branch),
    .i_branch_cond (branch_cond),
    .i_req_jump    (req_jump),
    .i_req_jr      (req_jr),
    .i_req_rte     (req_rte),
    .i_exc_opcode  (exc_opcode),
    .i_exc_ovf     (exc_ovf),
    .i_exc_div0    (exc_div0),
    .o_valid       (w_valid),
    .o_is_exc      (w_is_exc),
    .o_any         (w_any),
    .o_code        (w_code),
    .o_vector      (w_vector),
    .o_cause       (w_cause)
  );

  // Next state and next registered outputs; pulses default low, selector/cause hold
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_pc_source_nxt = r_pc_source;
    w_pc_write_nxt  = 1'b0;
    w_epc_write_nxt = 1'b0;
    w_mem_rd_nxt    = 1'b0;
    w_mem_addr_nxt  = 8'h00;
    w_cause_nxt     = r_cause;
    w_overrun_nxt   = r_overrun | ((r_state != ST_IDLE) & w_any);
    case (r_state)
      ST_IDLE: begin
        if (w_valid && w_is_exc) begin
          w_state_nxt     = ST_EXC_SAVE;
          w_epc_write_nxt = 1'b1;
          w_mem_rd_nxt    = 1'b1;
          w_mem_addr_nxt  = w_vector;
          w_cause_nxt     = w_cause;
        end else if (w_valid) begin
          w_state_nxt     = ST_COMMIT;
          w_pc_write_nxt  = 1'b1;
          w_pc_source_nxt = w_code;
        end
      end
      ST_EXC_SAVE: begin
        w_state_nxt = ST_EXC_WAIT;
        w_cnt_nxt   = 3'(MEM_LAT - 1);
      end
      ST_EXC_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt     = ST_COMMIT;
          w_pc_write_nxt  = 1'b1;
          w_pc_source_nxt = PCS_VEC;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;  // ST_COMMIT lasts one cycle
    endcase
  end

  // State and output registers; reset aborts any sequence in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
      r_pc_source <= PCS_SEQ;
      r_pc_write  <= 1'b0;
      r_epc_write <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= 8'h00;
      r_cause     <= CAUSE_NONE;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pc_source <= w_pc_source_nxt;
      r_pc_write  <= w_pc_write_nxt;
      r_epc_write <= w_epc_write_nxt;
      r_mem_rd    <= w_mem_rd_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_cause     <= w_cause_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_overrun   <= w_overrun_nxt;
    end
  end

  assign pc_source    = r_pc_source;
  assign pc_write     = r_pc_write;
  assign epc_write    = r_epc_write;
  assign exc_mem_rd   = r_mem_rd;
  assign exc_mem_addr = r_mem_addr;
  assign cause        = r_cause;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule
